// File: rtl/wr_ptr_ctrl_v2_pkg.sv
// Shared pointer defaults and gray/binary helpers for the async FIFO
// pointer controllers (write side and read side).
package parameters_pkg;

  // Default geometry of the FIFO and depth of the pointer synchronisers.
  localparam int ADDR_WIDTH_DEF  = 3;
  localparam int SYNC_STAGES_DEF = 2;

  // Pointer helpers work on a wide container; callers zero-extend their
  // PTR_WIDTH-bit pointer into it and cast the result back down. Zero
  // upper bits are transparent to both conversions, so one pair of
  // functions serves every pointer width up to MAX_PTR_WIDTH.
  localparam int MAX_PTR_WIDTH = 32;
  typedef logic [MAX_PTR_WIDTH-1:0] ptr_vec_t;

  // Binary to reflected gray code.
  function automatic ptr_vec_t bin2gray(input ptr_vec_t bin_v);
    return bin_v ^ (bin_v >> 1);
  endfunction

  // Reflected gray code to binary: each binary bit is the XOR of all
  // gray bits at and above it.
  function automatic ptr_vec_t gray2bin(input ptr_vec_t gray_v);
    ptr_vec_t bin_v;
    bin_v[MAX_PTR_WIDTH-1] = gray_v[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin_v[i] = bin_v[i+1] ^ gray_v[i];
    end
    return bin_v;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a gray-coded bus. Only one bit of the bus
// changes per source update, so a per-bit flop chain is safe here.
module cdc_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous bus through STAGES flops; all stages clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl_v2.sv
// Write-side pointer controller for the async FIFO. Keeps the binary and
// gray write pointers, synchronises the read-domain gray pointer and
// derives registered FULL / ALMOST_FULL / fill level plus a sticky
// OVERFLOW flag. All status flags are computed from the *next* write
// pointer so they change on the same edge that moves the pointer.
module wr_ptr_ctrl_v2
  import parameters_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int PTR_WIDTH   = ADDR_WIDTH + 1,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AF_LEVEL    = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic                  OVF_CLR,
  input  logic [PTR_WIDTH-1:0]  g_rptr_async,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0]  g_wptr,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [PTR_WIDTH-1:0]  wr_level,
  output logic                  OVERFLOW
);

  // The FIFO is full when the write pointer has lapped the read pointer
  // once: in gray code that is "top two bits inverted, rest equal".
  localparam logic [PTR_WIDTH-1:0] FULL_MASK  = {2'b11, {(PTR_WIDTH-2){1'b0}}};
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL_C = PTR_WIDTH'(AF_LEVEL);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH-1:0] PTR_ZERO   = {PTR_WIDTH{1'b0}};

  // Registered state and its next-state values.
  logic [PTR_WIDTH-1:0] b_wptr_q, b_wptr_d;
  logic [PTR_WIDTH-1:0] g_wptr_q, g_wptr_d;
  logic [PTR_WIDTH-1:0] level_q,  level_d;
  logic                 full_q,   full_d;
  logic                 af_q,     af_d;
  logic                 ovf_q,    ovf_d;

  // Combinational helpers.
  logic                 wr_en_s;
  logic [PTR_WIDTH-1:0] g_rptr_sync_s;
  logic [PTR_WIDTH-1:0] b_rptr_sync_s;

  // Bring the read-domain gray pointer into the write clock domain.
  cdc_sync_bus #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (W_CLK),
    .rst_ni (W_RST),
    .d_i    (g_rptr_async),
    .q_o    (g_rptr_sync_s)
  );

  // Accept a write only while not full; advance the binary pointer and
  // its gray image together so g_wptr is always gray(b_wptr).
  always_comb begin
    wr_en_s  = W_INC & ~full_q;
    if (wr_en_s) begin
      b_wptr_d = b_wptr_q + PTR_ONE;
    end else begin
      b_wptr_d = b_wptr_q;
    end
    g_wptr_d = PTR_WIDTH'(bin2gray(ptr_vec_t'(b_wptr_d)));
  end

  // Status flags from the next write pointer and the synchronised read
  // pointer. A stale read pointer can only overstate occupancy, so FULL
  // errs on the safe side.
  always_comb begin
    b_rptr_sync_s = PTR_WIDTH'(gray2bin(ptr_vec_t'(g_rptr_sync_s)));
    full_d        = (g_wptr_d == (g_rptr_sync_s ^ FULL_MASK));
    level_d       = b_wptr_d - b_rptr_sync_s;
    af_d          = (level_d >= AF_LEVEL_C);
  end

  // Sticky overflow: a write attempt while full sets it, OVF_CLR clears
  // it, and a coincident attempt beats the clear.
  always_comb begin
    if (W_INC & full_q) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pointer and flag registers; reset drops any in-flight write.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      b_wptr_q <= PTR_ZERO;
      g_wptr_q <= PTR_ZERO;
      level_q  <= PTR_ZERO;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr       = b_wptr_q[ADDR_WIDTH-1:0];
  assign g_wptr      = g_wptr_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = af_q;
  assign wr_level    = level_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: doc/wr_ptr_ctrl_v2.md
Name: wr_ptr_ctrl_v2

Overview:
- Parametrised write-side pointer controller for the async FIFO, second generation.
- Generates the write address and a registered, glitch-free gray write pointer for CDC. It also synchronises the raw read-domain gray pointer internally.
- Produces registered FULL, ALMOST_FULL, a fill-level count and a sticky OVERFLOW error flag.
- Sits in the write clock domain between the write client and the FIFO memory / read-side pointer logic.

Parameters:
- ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH.
- PTR_WIDTH, ADDR_WIDTH+1, pointer width including the wrap bit. Derived; must not be overridden.
- SYNC_STAGES, 2, flop stages in the read-pointer synchroniser; legal range 2..4.
- AF_LEVEL, DEPTH-2, fill level at or above which ALMOST_FULL asserts; legal range 1..DEPTH.

Ports:
- W_CLK  in  1  write-domain clock.
- W_RST  in  1  asynchronous active-low reset.
- W_INC  in  1  write request from the client.
- OVF_CLR  in  1  synchronous clear of the sticky OVERFLOW flag.
- g_rptr_async  in  PTR_WIDTH  gray read pointer straight from the read domain, not yet synchronised.
- waddr  out  ADDR_WIDTH  memory write address, equal to b_wptr[ADDR_WIDTH-1:0].
- g_wptr  out  PTR_WIDTH  registered gray write pointer, sent to the read domain.
- FULL  out  1  registered full flag.
- ALMOST_FULL  out  1  registered flag; asserts when wr_level >= AF_LEVEL.
- wr_level  out  PTR_WIDTH  registered occupancy as seen from the write side, 0..DEPTH.
- OVERFLOW  out  1  sticky flag for a write attempted while FULL.

Behaviour:
- Reset (W_RST low, asynchronous): the following all go to 0.
  - b_wptr, g_wptr and every synchroniser stage.
  - FULL, ALMOST_FULL, wr_level and OVERFLOW.
- Reset may assert mid-write; the in-flight write is dropped and no partial state remains.
- Accept: wr_en = W_INC & ~FULL. On each W_CLK rise, b_wptr <= b_wptr + wr_en, wrapping modulo 2**PTR_WIDTH.
- Gray pointer: g_wptr <= gray(b_wptr + wr_en). It is registered in the same cycle as b_wptr, so g_wptr always equals gray(b_wptr) and never carries combinational glitches.
- Synchroniser: g_rptr_async passes through a SYNC_STAGES-deep flop chain to give g_rptr_sync. b_rptr_sync = gray2bin(g_rptr_sync), combinational.
- Next-state values are all computed from the next write pointer:
  - full_next: gray(b_wptr+wr_en) equals g_rptr_sync with its two MSBs inverted and the remaining bits equal.
  - level_next = (b_wptr + wr_en) - b_rptr_sync, modulo 2**PTR_WIDTH.
  - FULL <= full_next.
  - wr_level <= level_next.
  - ALMOST_FULL <= (level_next >= AF_LEVEL).
- Latency:
  - Write accepted in cycle N: FULL, wr_level and ALMOST_FULL reflect it at the same edge that updates b_wptr.
  - Read-pointer change at g_rptr_async: seen by FULL after SYNC_STAGES+1 edges.
- FULL is pessimistic: it may remain high after reads until the synchroniser catches up. It never indicates false not-full.
- OVERFLOW:
  - Set when W_INC & FULL at a clock edge.
  - Cleared when OVF_CLR.
  - If both occur in the same cycle, set wins.
  - The write pointer does not move on an overflow attempt.
- Wrap-around: after 2*DEPTH accepted writes, b_wptr returns to 0. FULL is detected correctly across the wrap-bit boundary.
- A simultaneous write and read-pointer update is handled naturally; level reflects both once the read update is synchronised.

Decomposition:
- Shared package parameters_pkg holds ADDR_WIDTH and SYNC_STAGES defaults, plus functions bin2gray() and gray2bin() with width generic via PTR_WIDTH.
- The read-side pointer handler reuses these functions.
- One sub-module: cdc_sync_bus, a parametrised width × SYNC_STAGES flop chain with async active-low reset. The read domain also instantiates it for the write pointer.

Test Plan:
- Reset: hold W_RST low with W_INC=1 → all outputs 0; after release with g_rptr_async=0, 8 consecutive W_INC (DEPTH 8):
  - waddr steps 0..7.
  - ALMOST_FULL rises after the 6th write.
  - FULL rises after the 8th write.
  - wr_level=8.
  - g_wptr=4'b1100.
- Overflow: FULL with W_INC held 3 cycles → b_wptr unchanged and OVERFLOW=1; pulse OVF_CLR with W_INC=0 → OVERFLOW=0; OVF_CLR and W_INC together while FULL → OVERFLOW stays 1.
- Sync latency: from FULL, drive g_rptr_async to gray(2)=4'b0011 → FULL drops and wr_level=6 exactly 3 edges later (SYNC_STAGES=2); ALMOST_FULL stays 1 at level 6.
- Wrap: stream 40 writes with the read pointer trailing by 3 → b_wptr wraps through 15→0, FULL never asserts, wr_level constant at 3, and every g_wptr step changes exactly one bit.
- Mid-operation reset: assert W_RST asynchronously between edges during a write burst → outputs 0 immediately, not at the next edge; normal operation resumes from waddr=0.
- Parameter sweep: ADDR_WIDTH=4 and SYNC_STAGES=3 → FULL at 16 entries, ALMOST_FULL at 14, read-to-FULL latency of 4 edges.
